debugger_put_hex: RTL and testbench
===================================

Name: debugger_put_hex

Overview:
- Debugger 32-bit value to uppercase hex text converter.
- Inverse of the debugger hex parser: a register or memory value is formatted into characters and written into the debugger's text line buffer at a given start index.
- Emits one character per clock through a single-port write strobe.
- Used by the debugger response builder (register dumps, memory dumps).

Parameters:
COUNT, 64, depth of the destination character buffer; writes never address at or beyond COUNT.

Ports:
CLK  input  1  clock.
RESET  input  1  asynchronous, active-high reset.
REQ_n  input  1  request, active low, four-phase handshake with ACK_n.
VALUE  input  32  value to format; sampled when the request is accepted.
DIGITS  input  4  digit count 1..8; 0 or >8 means 8; sampled when the request is accepted.
SUPPRESS  input  1  1 = drop leading zero digits (last digit always written); sampled when the request is accepted.
START  input  $clog2(COUNT+1)+1  first buffer index to write.
ACK_n  output  1  completion acknowledge, active low.
INDEX  output  $clog2(COUNT+1)+1  next free buffer index (one past the last written character).
OVERFLOW  output  1  1 = output truncated because the buffer end was reached.
WR_EN  output  1  one-cycle write strobe.
WR_ADDR  output  $clog2(COUNT+1)+1  buffer write index.
WR_DATA  output  8  character code: CHAR_0..CHAR_9 and CHAR_A..CHAR_F from the debugger character include (ASCII 0x30..0x39, 0x41..0x46).

Behaviour:
- Reset values (asynchronous, while RESET=1):
  - ACK_n=1, INDEX=0, OVERFLOW=0, WR_EN=0, WR_ADDR=0, WR_DATA=0.
  - State=IDLE; internal shift register, digit counter and seen-nonzero flag cleared.
- All outputs are registered.
- States: IDLE, EMIT, COMPLETE.
- IDLE, on an edge with REQ_n=0:
  - Latch n = effective DIGITS.
  - Latch SHIFT = VALUE << 4*(8-n), so the first digit is in SHIFT[31:28].
  - Latch SUPPRESS.
  - INDEX<=START, OVERFLOW<=0, remaining<=n, seen<=0.
  - Go to EMIT.
  - ACK_n stays 1.
- EMIT, each edge:
  - If INDEX>=COUNT: OVERFLOW<=1, WR_EN<=0, go to COMPLETE, ACK_n<=0.
  - Otherwise, with nib = SHIFT[31:28] and last = (remaining==1):
    - Skip case, when SUPPRESS=1, nib=0, seen=0 and not last: WR_EN<=0, INDEX unchanged.
    - Write case, otherwise: WR_EN<=1, WR_ADDR<=INDEX, WR_DATA<=char(nib), INDEX<=INDEX+1, seen<=1.
    - In both cases: SHIFT<=SHIFT<<4, remaining<=remaining-1.
    - If last: go to COMPLETE, ACK_n<=0 on the same edge.
- COMPLETE:
  - WR_EN<=0.
  - While REQ_n=0: hold ACK_n=0; no new conversion starts.
  - On an edge with REQ_n=1: ACK_n<=1, go to IDLE.
- Latency:
  - Request accepted at edge k; digit i (0-based) is produced at edge k+1+i.
  - With no suppression and no overflow: WR_EN high for exactly n consecutive cycles; ACK_n falls at edge k+n.
  - ACK_n falls on the same edge that writes the last digit.
  - INDEX is final when ACK_n falls.
- INDEX is valid from ACK_n=0 until the next accepted request.
- REQ_n rising before completion is ignored and the conversion finishes. ACK_n then falls and rises on the following edge (one-cycle low pulse).
- VALUE, DIGITS, SUPPRESS and START may change after acceptance without effect.
- START>=COUNT: no writes, OVERFLOW=1, INDEX=START, ACK_n falls at edge k+1.
- Reset mid-operation: immediate return to the reset state. Writes already issued are not retracted; WR_EN drops asynchronously.
- Index arithmetic is unsigned and wide enough to hold COUNT without wrap.

Test Plan:
- COUNT=64, VALUE=0x0000BEEF, DIGITS=4, SUPPRESS=0, START=3, REQ_n low at edge k -> WR_EN high at edges k+1..k+4 with (addr,data)=(3,0x42),(4,0x45),(5,0x45),(6,0x46); ACK_n=0 at edge k+4; INDEX=7; OVERFLOW=0.
- VALUE=0x00000A05, DIGITS=8, SUPPRESS=1, START=0 -> five cycles with WR_EN=0, then writes (0,0x41),(1,0x30),(2,0x35); INDEX=3; ACK_n falls 8 edges after acceptance.
- VALUE=0, DIGITS=0 (treated as 8), SUPPRESS=1, START=10 -> exactly one write (10,0x30); INDEX=11.
- COUNT=64, VALUE=0x1234, DIGITS=4, START=62 -> writes (62,0x31),(63,0x32); then OVERFLOW=1, INDEX=64, ACK_n=0; no write at address 64.
- Handshake: REQ_n held low 10 cycles past completion -> ACK_n stays 0, no further writes. REQ_n high -> ACK_n=1 one edge later. REQ_n low again -> fresh conversion with OVERFLOW cleared.
- RESET pulsed after the second digit of an 8-digit conversion -> WR_EN, ACK_n=1, INDEX=0 immediately. The next request (VALUE=0xDEADBEEF, DIGITS=8, START=0) writes "DEADBEEF" at 0..7.

Source files
------------

// File: rtl/debugger_put_hex_if.sv
`default_nettype none
// ============================================================================
// Module      : debugger_put_hex_if
// Description : Request/acknowledge and buffer-write bundle for the debugger
//               32-bit to uppercase-hex text converter.
//               master : the requester (response builder / testbench)
//               slave  : the converter (debugger_put_hex)
//               Signals:
//                 REQ_n    request, active low, four-phase with ACK_n
//                 VALUE    value to format
//                 DIGITS   digit count (0 or >8 means 8)
//                 SUPPRESS drop leading zero digits
//                 START    first buffer index to write
//                 ACK_n    completion acknowledge, active low
//                 INDEX    next free buffer index after the conversion
//                 OVERFLOW output truncated at the end of the buffer
//                 WR_EN    one-cycle write strobe
//                 WR_ADDR  buffer write index
//                 WR_DATA  ASCII character
// Revision    : 1.0 - initial release
// ============================================================================
interface debugger_put_hex_if #(
  parameter int COUNT = 64
);
  localparam int c_IW = $clog2(COUNT + 1) + 1;

  logic            REQ_n;
  logic [31:0]     VALUE;
  logic [3:0]      DIGITS;
  logic            SUPPRESS;
  logic [c_IW-1:0] START;
  logic            ACK_n;
  logic [c_IW-1:0] INDEX;
  logic            OVERFLOW;
  logic            WR_EN;
  logic [c_IW-1:0] WR_ADDR;
  logic [7:0]      WR_DATA;

  modport master (
    output REQ_n, VALUE, DIGITS, SUPPRESS, START,
    input  ACK_n, INDEX, OVERFLOW, WR_EN, WR_ADDR, WR_DATA
  );

  modport slave (
    input  REQ_n, VALUE, DIGITS, SUPPRESS, START,
    output ACK_n, INDEX, OVERFLOW, WR_EN, WR_ADDR, WR_DATA
  );
endinterface
`default_nettype wire

// File: rtl/debugger_put_hex.sv
`default_nettype none
// ============================================================================
// Module      : debugger_put_hex
// Description : Formats a 32-bit value as 1..8 uppercase hex characters and
//               writes them, one per clock, into the debugger text line
//               buffer starting at bus.START. Leading zeros may be dropped
//               (the last digit is always written). Writing stops at COUNT
//               and OVERFLOW is flagged. Completion is signalled by ACK_n
//               falling on the edge that writes the final character.
//               Ports:
//                 CLK    clock
//                 RESET  asynchronous active-high reset
//                 bus    debugger_put_hex_if slave (request, result, write)
// Revision    : 1.0 - initial release
// ============================================================================
module debugger_put_hex #(
  parameter int COUNT = 64
) (
  input  wire logic         CLK,
  input  wire logic         RESET,
  debugger_put_hex_if.slave bus
);

  localparam int c_IW = $clog2(COUNT + 1) + 1;
  localparam logic [c_IW-1:0] c_LIMIT = c_IW'(COUNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     shift_q, shift_d;
  logic [3:0]      remaining_q, remaining_d;
  logic            seen_q, seen_d;
  logic            suppress_q, suppress_d;
  logic [c_IW-1:0] index_q, index_d;
  logic            overflow_q, overflow_d;
  logic            ack_n_q, ack_n_d;
  logic            wr_en_q, wr_en_d;
  logic [c_IW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  // Effective digit count and the left shift that parks the first digit
  // in the top nibble.
  logic [3:0] w_eff;
  logic [4:0] w_pad;
  logic [3:0] w_nib;
  logic       w_last;
  logic [7:0] w_char;

  assign w_eff  = ((bus.DIGITS == 4'd0) || (bus.DIGITS > 4'd8)) ? 4'd8 : bus.DIGITS;
  assign w_pad  = 5'd8 - {1'b0, w_eff};
  assign w_nib  = shift_q[31:28];
  assign w_last = (remaining_q == 4'd1);
  assign w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                  : (8'h37 + {4'h0, w_nib});

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    seen_d      = seen_q;
    suppress_d  = suppress_q;
    index_d     = index_q;
    overflow_d  = overflow_q;
    ack_n_d     = ack_n_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      IDLE: begin
        if (!bus.REQ_n) begin
          shift_d     = bus.VALUE << {w_pad, 2'b00};
          remaining_d = w_eff;
          suppress_d  = bus.SUPPRESS;
          seen_d      = 1'b0;
          index_d     = bus.START;
          overflow_d  = 1'b0;
          state_d     = EMIT;
        end
      end

      EMIT: begin
        if (index_q >= c_LIMIT) begin
          overflow_d = 1'b1;
          ack_n_d    = 1'b0;
          state_d    = COMPLETE;
        end else begin
          // A leading zero is skipped only while no digit has been written
          // yet, and never for the final digit, so "0" prints as one char.
          if (!(suppress_q && (w_nib == 4'd0) && !seen_q && !w_last)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = index_q;
            wr_data_d = w_char;
            index_d   = index_q + c_IW'(1);
            seen_d    = 1'b1;
          end
          shift_d     = shift_q << 4;
          remaining_d = remaining_q - 4'd1;
          if (w_last) begin
            ack_n_d = 1'b0;
            state_d = COMPLETE;
          end
        end
      end

      COMPLETE: begin
        // Requester may already have released REQ_n; ACK_n then forms a
        // single-cycle low pulse.
        if (bus.REQ_n) begin
          ack_n_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ack_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      shift_q     <= 32'h0;
      remaining_q <= 4'd0;
      seen_q      <= 1'b0;
      suppress_q  <= 1'b0;
      index_q     <= '0;
      overflow_q  <= 1'b0;
      ack_n_q     <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      seen_q      <= seen_d;
      suppress_q  <= suppress_d;
      index_q     <= index_d;
      overflow_q  <= overflow_d;
      ack_n_q     <= ack_n_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.ACK_n    = ack_n_q;
  assign bus.INDEX    = index_q;
  assign bus.OVERFLOW = overflow_q;
  assign bus.WR_EN    = wr_en_q;
  assign bus.WR_ADDR  = wr_addr_q;
  assign bus.WR_DATA  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_debugger_put_hex.sv
`default_nettype none
// ============================================================================
// Module      : tb_debugger_put_hex
// Description : Self-checking bench for debugger_put_hex. Expected buffer
//               writes (address, character, edge number) are queued when a
//               request is driven and compared as WR_EN strobes appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debugger_put_hex;

  localparam int COUNT = 64;
  localparam int IW    = $clog2(COUNT + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int addr;
    int data;
    int at_edge;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debugger_put_hex_if #(.COUNT(COUNT)) bus ();

  debugger_put_hex #(.COUNT(COUNT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  function automatic int char_of(input int nib);
    return (nib < 10) ? (32'h30 + nib) : (32'h41 + nib - 10);
  endfunction

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.WR_EN === 1'b1) begin
      checks++;
      if (bus.WR_ADDR >= IW'(COUNT)) begin
        errors++;
        $display("FAIL write_bound addr=%0d required < %0d", bus.WR_ADDR, COUNT);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h edge=%0d required no write",
                 bus.WR_ADDR, bus.WR_DATA, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.WR_ADDR !== IW'(e.addr) || bus.WR_DATA !== e.data[7:0] || cyc != e.at_edge) begin
          errors++;
          $display("FAIL write addr=%0d data=%h edge=%0d required addr=%0d data=%h edge=%0d",
                   bus.WR_ADDR, bus.WR_DATA, cyc, e.addr, e.data[7:0], e.at_edge);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Drive one request, queue its expected writes, wait for ACK_n and check
  // latency (edges after acceptance), INDEX and OVERFLOW. REQ_n stays low.
  task automatic run_req(input string name, input logic [31:0] value, input logic [3:0] digits,
                         input logic sup, input int start, input int exp_lat,
                         input int exp_index, input logic exp_ovf);
    int   k, n, idx, cnt, nib;
    bit   seen;
    exp_t e;
    @(negedge clk);
    bus.VALUE    = value;
    bus.DIGITS   = digits;
    bus.SUPPRESS = sup;
    bus.START    = IW'(start);
    bus.REQ_n    = 1'b0;
    k    = cyc + 1;
    n    = (digits == 0 || digits > 8) ? 8 : int'(digits);
    idx  = start;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (idx >= COUNT) break;
      nib = int'((value >> (4 * (n - 1 - i))) & 32'hF);
      if (!(sup && nib == 0 && !seen && i != n - 1)) begin
        e.addr = idx; e.data = char_of(nib); e.at_edge = k + 1 + i;
        sb.push_back(e);
        idx++;
        seen = 1;
      end
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        bus.VALUE    = ~value;
        bus.DIGITS   = 4'd3;
        bus.SUPPRESS = ~sup;
        bus.START    = '0;
      end
    end while (bus.ACK_n !== 1'b0 && cnt < 30);
    checks++;
    if (cnt - 1 != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d required %0d", name, cnt - 1, exp_lat);
    end
    checks++;
    if (bus.INDEX !== IW'(exp_index)) begin
      errors++;
      $display("FAIL %s index got %0d required %0d", name, bus.INDEX, exp_index);
    end
    checks++;
    if (bus.OVERFLOW !== exp_ovf) begin
      errors++;
      $display("FAIL %s overflow got %0b required %0b", name, bus.OVERFLOW, exp_ovf);
    end
  endtask

  task automatic release_req(input string name);
    @(negedge clk);
    bus.REQ_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ACK_n !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_release got %0b required 1", name, bus.ACK_n);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.REQ_n = 1'b1; bus.VALUE = '0; bus.DIGITS = '0; bus.SUPPRESS = 1'b0; bus.START = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ACK_n !== 1'b1 || bus.INDEX !== '0 || bus.OVERFLOW !== 1'b0 ||
        bus.WR_EN !== 1'b0 || bus.WR_ADDR !== '0 || bus.WR_DATA !== 8'h00) begin
      errors++;
      $display("FAIL reset_state ack=%0b idx=%0d ovf=%0b wr=%0b addr=%0d data=%h required 1 0 0 0 0 00",
               bus.ACK_n, bus.INDEX, bus.OVERFLOW, bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_req("beef", 32'h0000BEEF, 4'd4, 1'b0, 3, 4, 7, 1'b0);
    release_req("beef");
  endtask

  task automatic test_suppress();
    run_req("a05", 32'h00000A05, 4'd8, 1'b1, 0, 8, 3, 1'b0);
    release_req("a05");
    run_req("zero", 32'h0, 4'd0, 1'b1, 10, 8, 11, 1'b0);
    release_req("zero");
  endtask

  task automatic test_start_overflow();
    run_req("start70", 32'h12345678, 4'd8, 1'b0, 70, 1, 70, 1'b1);
    release_req("start70");
  endtask

  task automatic test_overflow_handshake();
    run_req("ovf62", 32'h00001234, 4'd4, 1'b0, 62, 3, 64, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ACK_n !== 1'b0) begin
        errors++;
        $display("FAIL hold_ack cycle %0d got %0b required 0", i, bus.ACK_n);
      end
    end
    release_req("ovf62");
    run_req("fresh", 32'h0000005A, 4'd2, 1'b0, 0, 2, 2, 1'b0);
    release_req("fresh");
  endtask

  task automatic test_early_release();
    int   k, cnt;
    exp_t e;
    @(negedge clk);
    bus.VALUE = 32'h000000C3; bus.DIGITS = 4'd2; bus.SUPPRESS = 1'b0; bus.START = IW'(20);
    bus.REQ_n = 1'b0;
    k = cyc + 1;
    e.addr = 20; e.data = 32'h43; e.at_edge = k + 1; sb.push_back(e);
    e.addr = 21; e.data = 32'h33; e.at_edge = k + 2; sb.push_back(e);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      bus.REQ_n = 1'b1;
    end while (bus.ACK_n !== 1'b0 && cnt < 30);
    checks++;
    if (cnt - 1 != 2) begin
      errors++;
      $display("FAIL early latency got %0d required 2", cnt - 1);
    end
    @(negedge clk);
    checks++;
    if (bus.ACK_n !== 1'b1) begin
      errors++;
      $display("FAIL early ack_pulse got %0b required 1", bus.ACK_n);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL early missing_writes got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int   k;
    exp_t e;
    @(negedge clk);
    bus.VALUE = 32'h12345678; bus.DIGITS = 4'd8; bus.SUPPRESS = 1'b0; bus.START = IW'(40);
    bus.REQ_n = 1'b0;
    k = cyc + 1;
    e.addr = 40; e.data = 32'h31; e.at_edge = k + 1; sb.push_back(e);
    e.addr = 41; e.data = 32'h32; e.at_edge = k + 2; sb.push_back(e);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.REQ_n = 1'b1;
    #1;
    checks++;
    if (bus.WR_EN !== 1'b0 || bus.ACK_n !== 1'b1 || bus.INDEX !== '0) begin
      errors++;
      $display("FAIL reset_mid wr=%0b ack=%0b idx=%0d required 0 1 0",
               bus.WR_EN, bus.ACK_n, bus.INDEX);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid pre_writes got %0d pending required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    rst = 1'b0;
    run_req("deadbeef", 32'hDEADBEEF, 4'd8, 1'b0, 0, 8, 8, 1'b0);
    release_req("deadbeef");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_suppress();
    test_start_overflow();
    test_overflow_handshake();
    test_early_release();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
